// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the screen pipeline.
//   fade_state_t : fade controller states (BLACK, FADE_IN, VISIBLE, FADE_OUT)
//   FADE_LEVEL_W : width of the fade level register (holds 0..16)
//   CHAN_W       : width of one colour channel inside the 12-bit rgb word
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int FADE_LEVEL_W = 5;
    localparam int CHAN_W       = 4;

    typedef enum logic [1:0] {
        BLACK    = 2'd0,
        FADE_IN  = 2'd1,
        VISIBLE  = 2'd2,
        FADE_OUT = 2'd3
    } fade_state_t;

endpackage

// File: rtl/game_if.sv
// ---------------------------------------------------------------------------
// game_if
// Pixel stream between screen stages: timing counters, sync/blank flags and
// a 12-bit rgb word (4 bits per channel, r in [11:8]).
// Modports:
//   out / master : producer side (drives every field)
//   in  / slave  : consumer side (samples every field)
// ---------------------------------------------------------------------------
interface game_if;

    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport in (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport slave (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

endinterface

// File: rtl/fade_ctrl.sv
// ---------------------------------------------------------------------------
// fade_ctrl
// Fade level controller. Tracks the fade state, detects the start of each
// vertical blank (frame tick), counts ticks and steps the level once every
// FRAMES_PER_STEP ticks towards the current target (0 or LEVEL_MAX).
// Ports:
//   clk, rst        : pixel clock, synchronous active-high reset
//   vblnk           : upstream vertical blank, used for the frame tick
//   fade_in_start   : one-cycle request to fade towards LEVEL_MAX
//   fade_out_start  : one-cycle request to fade towards 0 (wins over in)
//   level           : current fade level 0..LEVEL_MAX
//   fade_busy       : high while in FADE_IN or FADE_OUT
//   fade_done       : one-cycle pulse when a fade reaches its end level
// ---------------------------------------------------------------------------
module fade_ctrl
    import game_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 2,
    parameter int LEVEL_MAX       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vblnk,
    input  logic                    fade_in_start,
    input  logic                    fade_out_start,
    output logic [FADE_LEVEL_W-1:0] level,
    output logic                    fade_busy,
    output logic                    fade_done
);

    localparam int CNT_W = $clog2(FRAMES_PER_STEP + 1);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [FADE_LEVEL_W-1:0] LVL_TOP  = FADE_LEVEL_W'(LEVEL_MAX);
    localparam logic [FADE_LEVEL_W-1:0] LVL_BOT  = '0;

    fade_state_t             state, state_n;
    logic [FADE_LEVEL_W-1:0] level_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic                    vblnk_d;
    logic                    tick;
    logic                    done_n;
    logic                    busy_n;

    // Frame tick = rising edge of vblnk, so the level only moves while the
    // screen is blanked and a visible frame never mixes two levels.
    assign tick = vblnk & ~vblnk_d;

    always_comb begin
        state_n = state;
        level_n = level;
        cnt_n   = cnt;
        done_n  = 1'b0;

        case (state)
            BLACK: begin
                // A simultaneous fade_out_start wins and is a no-op here.
                if (fade_in_start && !fade_out_start) begin
                    state_n = FADE_IN;
                    cnt_n   = '0;
                end
            end

            VISIBLE: begin
                if (fade_out_start) begin
                    state_n = FADE_OUT;
                    cnt_n   = '0;
                end
            end

            FADE_IN: begin
                if (fade_out_start) begin
                    // Reverse from the current level; if we never left 0
                    // there is nothing to fade, so settle silently.
                    cnt_n   = '0;
                    state_n = (level == LVL_BOT) ? BLACK : FADE_OUT;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        level_n = (level == LVL_TOP) ? level : level + 1'b1;
                        if (level_n == LVL_TOP) begin
                            state_n = VISIBLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end

            FADE_OUT: begin
                if (fade_in_start && !fade_out_start) begin
                    cnt_n   = '0;
                    state_n = (level == LVL_TOP) ? VISIBLE : FADE_IN;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        level_n = (level == LVL_BOT) ? level : level - 1'b1;
                        if (level_n == LVL_BOT) begin
                            state_n = BLACK;
                            done_n  = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_n = BLACK;
                level_n = LVL_BOT;
                cnt_n   = '0;
            end
        endcase

        busy_n = (state_n == FADE_IN) || (state_n == FADE_OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BLACK;
            level     <= '0;
            cnt       <= '0;
            vblnk_d   <= 1'b0;
            fade_busy <= 1'b0;
            fade_done <= 1'b0;
        end else begin
            state     <= state_n;
            level     <= level_n;
            cnt       <= cnt_n;
            vblnk_d   <= vblnk;
            fade_busy <= busy_n;
            fade_done <= done_n;
        end
    end

endmodule

// File: rtl/screen_fader.sv
// ---------------------------------------------------------------------------
// screen_fader
// One-cycle pipeline stage between the screen controllers and the VGA output
// register. Timing fields pass through delayed by one clock; each 4-bit rgb
// channel is scaled by the fade level held in fade_ctrl. Blanked pixels are
// forced to 0.
// Build option: define SCREEN_FADER_WHITE_EN to fade towards white instead
// of black (c + ((15-c)*(16-level))>>4). Control behaviour is identical.
// Ports:
//   clk, rst        : pixel clock, synchronous active-high reset
//   in              : upstream pixel stream (game_if.in)
//   out             : delayed, faded pixel stream (game_if.out)
//   fade_in_start   : one-cycle request to fade in
//   fade_out_start  : one-cycle request to fade out
//   fade_busy       : high while the level is moving
//   fade_done       : one-cycle pulse when the level reaches its target
// ---------------------------------------------------------------------------
module screen_fader
    import game_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 2,
    parameter int LEVEL_MAX       = 16
) (
    input  logic clk,
    input  logic rst,
    game_if.in   in,
    game_if.out  out,
    input  logic fade_in_start,
    input  logic fade_out_start,
    output logic fade_busy,
    output logic fade_done
);

    localparam logic [7:0] LVL_FULL = 8'(LEVEL_MAX);

    logic [FADE_LEVEL_W-1:0] level;

    logic [10:0] hcount_p0;
    logic [10:0] vcount_p0;
    logic        hsync_p0;
    logic        vsync_p0;
    logic        hblnk_p0;
    logic        vblnk_p0;
    logic [11:0] rgb_p0;
    logic [11:0] rgb_scaled;

    fade_ctrl #(
        .FRAMES_PER_STEP (FRAMES_PER_STEP),
        .LEVEL_MAX       (LEVEL_MAX)
    ) u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .vblnk          (in.vblnk),
        .fade_in_start  (fade_in_start),
        .fade_out_start (fade_out_start),
        .level          (level),
        .fade_busy      (fade_busy),
        .fade_done      (fade_done)
    );

    // Scale one channel by the level using an 8-bit product; the >>4 keeps
    // level 16 as unity gain and never overflows the 4-bit channel.
    function automatic logic [CHAN_W-1:0] scale_chan(
        input logic [CHAN_W-1:0]       c,
        input logic [FADE_LEVEL_W-1:0] lvl
    );
        logic [7:0] prod;
`ifdef SCREEN_FADER_WHITE_EN
        // Add back a fraction of the headroom to white; the added term is
        // at most 15-c, so the sum stays within 4 bits.
        prod = 8'(4'd15 - c) * (LVL_FULL - 8'(lvl));
        return c + prod[7:4];
`else
        prod = 8'(c) * 8'(lvl);
        return prod[7:4];
`endif
    endfunction

    always_comb begin
        rgb_scaled = {scale_chan(in.rgb[11:8], level),
                      scale_chan(in.rgb[7:4],  level),
                      scale_chan(in.rgb[3:0],  level)};
    end

    // Stage p0: register timing fields and the faded colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_p0 <= '0;
            vcount_p0 <= '0;
            hsync_p0  <= 1'b0;
            vsync_p0  <= 1'b0;
            hblnk_p0  <= 1'b0;
            vblnk_p0  <= 1'b0;
            rgb_p0    <= '0;
        end else begin
            hcount_p0 <= in.hcount;
            vcount_p0 <= in.vcount;
            hsync_p0  <= in.hsync;
            vsync_p0  <= in.vsync;
            hblnk_p0  <= in.hblnk;
            vblnk_p0  <= in.vblnk;
            rgb_p0    <= (in.hblnk || in.vblnk) ? 12'h000 : rgb_scaled;
        end
    end

    assign out.hcount = hcount_p0;
    assign out.vcount = vcount_p0;
    assign out.hsync  = hsync_p0;
    assign out.vsync  = vsync_p0;
    assign out.hblnk  = hblnk_p0;
    assign out.vblnk  = vblnk_p0;
    assign out.rgb    = rgb_p0;

endmodule

// File: tb/tb_screen_fader.sv
// ---------------------------------------------------------------------------
// tb_screen_fader
// Self-checking bench for screen_fader. A behavioural model tracks the fade
// level as "target + moving + frames seen" and predicts every output field.
// ---------------------------------------------------------------------------
module tb_screen_fader;

    localparam int FPS = 2;
    localparam int LMAX = 16;

    logic clk = 1'b0;
    logic rst;
    logic fade_in_start;
    logic fade_out_start;
    logic fade_busy;
    logic fade_done;

    game_if g_in ();
    game_if g_out ();

    screen_fader #(
        .FRAMES_PER_STEP (FPS),
        .LEVEL_MAX       (LMAX)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in             (g_in),
        .out            (g_out),
        .fade_in_start  (fade_in_start),
        .fade_out_start (fade_out_start),
        .fade_busy      (fade_busy),
        .fade_done      (fade_done)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Stimulus for the next clock
    logic        d_rst = 1'b1;
    logic        d_fin = 1'b0;
    logic        d_fout = 1'b0;
    logic [10:0] d_hc = '0;
    logic [10:0] d_vc = '0;
    logic        d_hs = 1'b0;
    logic        d_vs = 1'b0;
    logic        d_hb = 1'b0;
    logic        d_vb = 1'b0;
    logic [11:0] d_rgb = '0;

    // Reference model
    int m_level  = 0;
    int m_target = 0;
    bit m_moving = 1'b0;
    int m_frames = 0;
    bit m_prev_vb = 1'b0;

    // Expected outputs after the most recent clock
    logic [10:0] e_hc, e_vc;
    logic        e_hs, e_vs, e_hb, e_vb;
    logic [11:0] e_rgb;
    logic        e_busy, e_done;

    function automatic logic [11:0] ref_rgb(input logic [11:0] px, input int lvl);
        logic [11:0] r;
        int c, o;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            c = int'(px[k*4 +: 4]);
`ifdef SCREEN_FADER_WHITE_EN
            o = c + ((15 - c) * (16 - lvl)) / 16;
`else
            o = (c * lvl) / 16;
`endif
            r[k*4 +: 4] = 4'(o);
        end
        return r;
    endfunction

    task automatic set_active(input logic [11:0] px);
        d_hb = 1'b0; d_vb = 1'b0; d_vs = 1'b0;
        d_hc = d_hc + 11'd1;
        d_hs = 1'(($urandom % 7) == 0);
        d_rgb = px;
    endtask

    task automatic set_vblank();
        d_vb = 1'b1; d_hb = 1'b0; d_vs = 1'b1; d_hs = 1'b0;
        d_vc = d_vc + 11'd1;
        d_rgb = 12'(  $urandom);
    endtask

    // One clock: apply stimulus, advance the model, sample 1 ns after the edge.
    task automatic cycle();
        bit tick, acc_in, acc_out, done;
        rst = d_rst; fade_in_start = d_fin; fade_out_start = d_fout;
        g_in.hcount = d_hc; g_in.vcount = d_vc; g_in.hsync = d_hs;
        g_in.vsync = d_vs; g_in.hblnk = d_hb; g_in.vblnk = d_vb; g_in.rgb = d_rgb;
        done = 1'b0;
        if (d_rst) begin
            {e_hc, e_vc, e_hs, e_vs, e_hb, e_vb, e_rgb} = '0;
            m_level = 0; m_target = 0; m_moving = 1'b0; m_frames = 0; m_prev_vb = 1'b0;
        end else begin
            e_hc = d_hc; e_vc = d_vc; e_hs = d_hs; e_vs = d_vs; e_hb = d_hb; e_vb = d_vb;
            e_rgb = (d_hb || d_vb) ? 12'h000 : ref_rgb(d_rgb, m_level);
            tick = d_vb && !m_prev_vb;
            m_prev_vb = d_vb;
            acc_out = d_fout && (m_moving ? (m_target == LMAX) : (m_level == LMAX));
            acc_in  = d_fin && !d_fout && (m_moving ? (m_target == 0) : (m_level == 0));
            if (acc_out) begin
                m_target = 0; m_frames = 0; m_moving = (m_level != 0);
            end else if (acc_in) begin
                m_target = LMAX; m_frames = 0; m_moving = (m_level != LMAX);
            end else if (tick && m_moving) begin
                m_frames++;
                if (m_frames == FPS) begin
                    m_frames = 0;
                    m_level += (m_target > m_level) ? 1 : -1;
                    if (m_level == m_target) begin
                        m_moving = 1'b0;
                        done = 1'b1;
                    end
                end
            end
        end
        e_busy = m_moving;
        e_done = done;
        @(posedge clk);
        #1;
        d_fin = 1'b0; d_fout = 1'b0;
    endtask

    task automatic do_reset();
        d_rst = 1'b1; cycle(); d_rst = 1'b0;
    endtask

    task automatic test_reset();
        d_hc = 11'd37; d_vc = 11'd5; d_rgb = 12'hFFF; d_vb = 1'b1; d_hs = 1'b1;
        do_reset();
        n_cmp++;
        if ({g_out.hcount, g_out.vcount, g_out.hsync, g_out.vsync, g_out.hblnk,
             g_out.vblnk, g_out.rgb, fade_busy, fade_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got hc=%0d rgb=%h busy=%b done=%b want all 0",
                     g_out.hcount, g_out.rgb, fade_busy, fade_done);
        end
        for (int i = 0; i < 4; i++) begin
            set_active(12'hFFF);
            cycle();
            n_cmp++;
            if (g_out.hcount !== d_hc) begin
                n_fail++;
                $display("FAIL reset_hcount_delay: got %0d want %0d", g_out.hcount, d_hc);
            end
            n_cmp++;
            if (g_out.rgb !== e_rgb) begin
                n_fail++;
                $display("FAIL reset_black_rgb: got %h want %h", g_out.rgb, e_rgb);
            end
        end
`ifndef SCREEN_FADER_WHITE_EN
        n_cmp++;
        if (g_out.rgb !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_rgb_zero: got %h want 000", g_out.rgb);
        end
`endif
    endtask

    task automatic test_fade_in();
        int ticks = 0;
        int dones = 0;
        do_reset();
        d_fin = 1'b1; set_active(12'(  $urandom)); cycle();
        for (int f = 0; f < 34; f++) begin
            for (int p = 0; p < 3; p++) begin
                set_active(12'(  $urandom)); cycle();
                n_cmp++;
                if (g_out.rgb !== e_rgb || fade_busy !== e_busy) begin
                    n_fail++;
                    $display("FAIL fade_in_px: got rgb=%h busy=%b want rgb=%h busy=%b",
                             g_out.rgb, fade_busy, e_rgb, e_busy);
                end
            end
            if (ticks == 16) begin
                set_active(12'hA5F); cycle();
                n_cmp++;
`ifdef SCREEN_FADER_WHITE_EN
                if (g_out.rgb !== 12'hCAF) begin
                    n_fail++;
                    $display("FAIL level8_rgb: got %h want CAF", g_out.rgb);
                end
`else
                if (g_out.rgb !== 12'h527) begin
                    n_fail++;
                    $display("FAIL level8_rgb: got %h want 527", g_out.rgb);
                end
`endif
            end
            set_vblank(); cycle(); ticks++;
            if (fade_done) dones++;
            n_cmp++;
            if (fade_done !== (ticks == 32) || fade_busy !== (ticks < 32)) begin
                n_fail++;
                $display("FAIL fade_in_tick%0d: got done=%b busy=%b want done=%b busy=%b",
                         ticks, fade_done, fade_busy, ticks == 32, ticks < 32);
            end
            set_vblank(); cycle();
            if (fade_done) dones++;
        end
        n_cmp++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL fade_in_done_count: got %0d want 1", dones);
        end
        set_active(12'hA5F); cycle();
        n_cmp++;
        if (g_out.rgb !== 12'hA5F) begin
            n_fail++;
            $display("FAIL visible_rgb: got %h want A5F", g_out.rgb);
        end
        // fade_in_start while already visible must do nothing
        d_fin = 1'b1; set_active(12'h123); cycle();
        dones = 0;
        for (int f = 0; f < 4; f++) begin
            set_vblank(); cycle();
            if (fade_done || fade_busy) dones++;
            set_active(12'h3C9); cycle();
            if (fade_done || fade_busy) dones++;
        end
        n_cmp++;
        if (dones != 0 || g_out.rgb !== 12'h3C9) begin
            n_fail++;
            $display("FAIL visible_ignore_in: got activity=%0d rgb=%h want 0 and 3C9",
                     dones, g_out.rgb);
        end
    endtask

    task automatic test_reverse();
        int dones = 0;
        int when = -1;
        do_reset();
        d_fin = 1'b1; set_active(12'h000); cycle();
        for (int t = 0; t < 12; t++) begin
            set_active(12'(  $urandom)); cycle();
            set_vblank(); cycle();
            if (fade_done) dones++;
            set_vblank(); cycle();
        end
        set_active(12'hFFF); cycle();
        n_cmp++;
        if (g_out.rgb !== ref_rgb(12'hFFF, 6)) begin
            n_fail++;
            $display("FAIL level6_rgb: got %h want %h", g_out.rgb, ref_rgb(12'hFFF, 6));
        end
        d_fout = 1'b1; set_active(12'hFFF); cycle();
        for (int t = 1; t <= 14; t++) begin
            set_vblank(); cycle();
            if (fade_done) begin dones++; when = t; end
            set_vblank(); cycle();
            if (fade_done) dones++;
            set_active(12'(  $urandom)); cycle();
            n_cmp++;
            if (g_out.rgb !== e_rgb || fade_busy !== (t < 12)) begin
                n_fail++;
                $display("FAIL reverse_t%0d: got rgb=%h busy=%b want rgb=%h busy=%b",
                         t, g_out.rgb, fade_busy, e_rgb, t < 12);
            end
        end
        n_cmp++;
        if (dones != 1 || when != 12) begin
            n_fail++;
            $display("FAIL reverse_done: got %0d pulses at tick %0d want 1 at tick 12",
                     dones, when);
        end
    endtask

    task automatic test_both_start();
        int act = 0;
        do_reset();
        d_fin = 1'b1; d_fout = 1'b1; set_active(12'h777); cycle();
        for (int f = 0; f < 6; f++) begin
            set_vblank(); cycle();
            if (fade_busy || fade_done) act++;
            set_active(12'hFFF); cycle();
            if (fade_busy || fade_done) act++;
        end
        n_cmp++;
        if (act != 0 || g_out.rgb !== ref_rgb(12'hFFF, 0)) begin
            n_fail++;
            $display("FAIL both_start: got activity=%0d rgb=%h want 0 and %h",
                     act, g_out.rgb, ref_rgb(12'hFFF, 0));
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        d_fin = 1'b1; set_active(12'h000); cycle();
        for (int t = 0; t < 32; t++) begin
            set_vblank(); cycle(); set_active(12'h000); cycle();
        end
        d_fout = 1'b1; cycle();
        for (int t = 0; t < 14; t++) begin
            set_vblank(); cycle(); set_active(12'h000); cycle();
        end
        set_active(12'hFFF); cycle();
        n_cmp++;
        if (g_out.rgb !== ref_rgb(12'hFFF, 9) || fade_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL level9_rgb: got %h busy=%b want %h busy=1",
                     g_out.rgb, fade_busy, ref_rgb(12'hFFF, 9));
        end
        d_rst = 1'b1; set_active(12'hFFF); d_hs = 1'b1; cycle(); d_rst = 1'b0;
        n_cmp++;
        if ({g_out.hcount, g_out.vcount, g_out.hsync, g_out.rgb, fade_busy, fade_done} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: got hc=%0d vc=%0d rgb=%h busy=%b want all 0",
                     g_out.hcount, g_out.vcount, g_out.rgb, fade_busy);
        end
        set_active(12'hFFF); cycle();
        n_cmp++;
        if (g_out.rgb !== ref_rgb(12'hFFF, 0)) begin
            n_fail++;
            $display("FAIL rst_mid_level0: got %h want %h", g_out.rgb, ref_rgb(12'hFFF, 0));
        end
    endtask

    task automatic test_random();
        int line_pos = 0;
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            line_pos = (line_pos + 1) % 24;
            if (line_pos >= 21) begin
                set_vblank();
            end else begin
                set_active(12'(  $urandom));
                d_hb = 1'(($urandom % 9) == 0);
            end
            d_fin  = 1'(($urandom % 250) == 0);
            d_fout = 1'(($urandom % 400) == 0);
            cycle();
            n_cmp++;
            if (g_out.rgb !== e_rgb || g_out.hcount !== e_hc || g_out.vcount !== e_vc ||
                g_out.hsync !== e_hs || g_out.vsync !== e_vs || g_out.hblnk !== e_hb ||
                g_out.vblnk !== e_vb || fade_busy !== e_busy || fade_done !== e_done) begin
                n_fail++;
                $display("FAIL random_c%0d: got rgb=%h hc=%0d busy=%b done=%b want rgb=%h hc=%0d busy=%b done=%b",
                         i, g_out.rgb, g_out.hcount, fade_busy, fade_done,
                         e_rgb, e_hc, e_busy, e_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fade_in();
        test_reverse();
        test_both_start();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
